pe_ws_vec: RTL and testbench

- Next-generation weight-stationary processing element: LANES parallel MAC lanes share one broadcast input activation.
- Each lane has its own stationary weight taken from a common scratchpad word of LANES weights.
- Weights are loaded through a valid/ready port and replayed cyclically over a runtime-programmable kernel length.
- Partial sums flow systolically through in/out valid/ready handshakes with full back-pressure and an optional saturating accumulate; the block tiles into array rows/columns.

---
 rtl/pe_pkg.sv | 38 +++
 rtl/pe_lane_mac.sv | 39 +++
 rtl/sync_dp_ram.sv | 33 +++
 rtl/pe_ws_vec.sv | 200 ++++++++++++++++++++
 tb/tb_pe_ws_vec.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the weight-stationary vector PE.
package pe_pkg;

    // Controller states: fill the weight scratchpad, stream activations,
    // then flush the pipeline before the next weight load.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } pe_state_e;

    // Widest accumulator the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Signed add clamped to a 'width'-bit signed range. Operands arrive
    // sign-extended to SAT_MAX_W bits and are assumed to already fit in
    // 'width' bits, so the 64-bit sum itself can never overflow. The
    // caller truncates the result back to 'width' bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] sum;
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_lane_mac.sv
// One MAC lane: psum_out = psum_in + sext(weight * iact), either wrapping
// modulo 2^ACC_WIDTH or clamped to the signed ACC_WIDTH range.
module pe_lane_mac
    import pe_pkg::*;
#(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 20,
    parameter bit SATURATE  = 1'b0
) (
    input  logic [OP_WIDTH-1:0]  weight,
    input  logic [OP_WIDTH-1:0]  iact,
    input  logic [ACC_WIDTH-1:0] psum_in,
    output logic [ACC_WIDTH-1:0] psum_out
);

    logic signed [2*OP_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  psum_s;

    // Full-precision signed product, sign-extended to the accumulator width.
    always_comb begin
        prod     = (2*OP_WIDTH)'($signed(weight)) * (2*OP_WIDTH)'($signed(iact));
        prod_ext = ACC_WIDTH'(prod);
        psum_s   = $signed(psum_in);
    end

    if (SATURATE) begin : g_sat
        // Clamp on overflow in either direction.
        always_comb begin
            psum_out = ACC_WIDTH'(sat_add(SAT_MAX_W'(psum_s), SAT_MAX_W'(prod_ext), ACC_WIDTH));
        end
    end else begin : g_wrap
        // Two's-complement wrap.
        always_comb begin
            psum_out = psum_in + prod_ext;
        end
    end

endmodule

// File: rtl/sync_dp_ram.sv
// Simple dual-port synchronous RAM: port A writes, port B reads.
// The read port only updates its output register when b_en is high, so
// the last read word is held while the reader is stalled.
module sync_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Registered read port with output hold.
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/pe_ws_vec.sv
// Weight-stationary vector processing element. LANES MAC lanes share one
// broadcast activation; each lane uses its own slice of a scratchpad word.
// Weights are replayed cyclically over a kernel of len_m1+1 words.
//
// Handshakes (w_*, in_*, out_*): a transfer happens on a rising clk edge
// exactly when valid && ready are both high; valid must not depend on
// ready, and a producer holds its data stable until the transfer.
module pe_ws_vec
    import pe_pkg::*;
#(
    parameter int OP_WIDTH   = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int LANES      = 4,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter bit SATURATE   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      cfg_len_m1,
    input  logic                       reload,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [LANES*OP_WIDTH-1:0]  w_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_WIDTH-1:0]        iact,
    input  logic [LANES*ACC_WIDTH-1:0] psum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*ACC_WIDTH-1:0] psum_out,
    output logic                       out_last,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);

    pe_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic [ADDR_WIDTH-1:0] len_eff;
    logic                  len_live;

    logic w_fire;
    logic in_fire;
    logic stall;
    logic enter_load;

    logic                       s1_valid;
    logic                       s1_last;
    logic [OP_WIDTH-1:0]        s1_iact;
    logic [LANES*ACC_WIDTH-1:0] s1_psum;

    logic [LANES*OP_WIDTH-1:0]  ram_rdata;
    logic [LANES*ACC_WIDTH-1:0] lane_sum;

    // Output register full and not taken: freeze the whole pipeline.
    assign stall      = out_valid && !out_ready;
    assign w_fire     = w_valid && w_ready;
    assign in_fire    = in_valid && in_ready;
    assign enter_load = (state_q == ST_DRAIN) && (state_d == ST_LOAD);
    assign state_dbg  = state_q;

    // Right after reset the kernel length follows cfg_len_m1 live, so the
    // value present at deassertion is the one captured and used.
    assign len_eff = len_live ? cfg_len_m1 : len_m1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake readies.
    always_comb begin
        state_d  = state_q;
        w_ready  = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_valid && (wr_ptr == len_eff)) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                busy     = 1'b1;
                in_ready = !stall;
                if (reload) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!s1_valid && (!out_valid || out_ready)) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Kernel length capture: once just after reset, then on every DRAIN->LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_live <= 1'b1;
            len_m1   <= '0;
        end else begin
            len_live <= 1'b0;
            if (len_live || enter_load) begin
                len_m1 <= cfg_len_m1;
            end
        end
    end

    // Scratchpad write and read pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (w_fire) begin
                if (wr_ptr == len_eff) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
            if (in_fire) begin
                rd_ptr <= (rd_ptr == len_eff) ? '0 : rd_ptr + ADDR_WIDTH'(1);
            end
            if (enter_load) begin
                wr_ptr <= '0;
            end
        end
    end

    // Weight scratchpad; the read is only issued for an accepted input so
    // the RAM output holds its word through a stall.
    sync_dp_ram #(
        .DATA_WIDTH (LANES*OP_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .a_we    (w_fire),
        .a_addr  (wr_ptr),
        .a_wdata (w_data),
        .b_en    (in_fire),
        .b_addr  (rd_ptr),
        .b_rdata (ram_rdata)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pe_lane_mac #(
            .OP_WIDTH  (OP_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_mac (
            .weight   (ram_rdata[l*OP_WIDTH +: OP_WIDTH]),
            .iact     (s1_iact),
            .psum_in  (s1_psum[l*ACC_WIDTH +: ACC_WIDTH]),
            .psum_out (lane_sum[l*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    // Two-stage pipeline: S1 aligns operands with the RAM read, S2 holds
    // the accumulated result. Both stages advance only when not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_iact   <= '0;
            s1_psum   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            psum_out  <= '0;
        end else if (!stall) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_iact <= iact;
                s1_psum <= psum_in;
                s1_last <= (rd_ptr == len_eff);
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                psum_out <= lane_sum;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_pe_ws_vec.sv
// Directed bench for pe_ws_vec: a wrapping instance and a saturating
// instance driven by the same stimulus, each with its own expected queue.
module tb_pe_ws_vec;

    localparam int AW = 8;
    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic [AW-1:0] cfg_len_m1;
    logic          reload;
    logic          w_valid;
    logic [31:0]   w_data;
    logic          in_valid;
    logic [7:0]    iact;
    logic [79:0]   psum_in;
    logic          out_ready;

    logic        w_ready, in_ready, out_valid, out_last, busy;
    logic [79:0] psum_out;
    logic [1:0]  state_dbg;

    logic        w_ready_s, in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [79:0] psum_out_s;
    logic [1:0]  state_dbg_s;

    pe_ws_vec #(
        .OP_WIDTH(8), .ACC_WIDTH(20), .LANES(4), .DEPTH(256), .SATURATE(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_len_m1(cfg_len_m1), .reload(reload),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .iact(iact), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
        .out_last(out_last), .busy(busy), .state_dbg(state_dbg)
    );

    pe_ws_vec #(
        .OP_WIDTH(8), .ACC_WIDTH(20), .LANES(4), .DEPTH(256), .SATURATE(1'b1)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .cfg_len_m1(cfg_len_m1), .reload(reload),
        .w_valid(w_valid), .w_ready(w_ready_s), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready_s), .iact(iact), .psum_in(psum_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .psum_out(psum_out_s),
        .out_last(out_last_s), .busy(busy_s), .state_dbg(state_dbg_s)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference helpers ----------------
    function automatic logic [31:0] pw(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [79:0] pp(input int a, input int b, input int c, input int d);
        return {20'(d), 20'(c), 20'(b), 20'(a)};
    endfunction

    function automatic logic [80:0] model(input logic [31:0] w, input logic signed [7:0] a,
                                          input logic [79:0] p, input logic last, input logic sat);
        logic [79:0] r;
        longint s;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            s = longint'($signed(w[l*8 +: 8])) * longint'(a) + longint'($signed(p[l*20 +: 20]));
            if (sat && s > 524287)  s = 524287;
            if (sat && s < -524288) s = -524288;
            r[l*20 +: 20] = s[19:0];
        end
        return {last, r};
    endfunction

    logic [31:0] w_tab [0:255];
    int m_idx = 0;
    int m_len = 0;

    // ---------------- scoreboard ----------------
    logic [80:0] exp_q[$];
    logic [80:0] exp_sat_q[$];
    logic [80:0] mon_e, mon_es;
    int first_acc = -1;
    int first_ov  = -1;
    logic stall_mon = 1'b0;
    int stall_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 96'(1), 96'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("psum_out", 96'(psum_out), 96'(mon_e[79:0]));
                    check("out_last", 96'(out_last), 96'(mon_e[80]));
                end
            end
            if (out_valid_s && out_ready) begin
                if (exp_sat_q.size() == 0) begin
                    check("sat_out_unexpected", 96'(1), 96'(0));
                end else begin
                    mon_es = exp_sat_q.pop_front();
                    check("sat_psum_out", 96'(psum_out_s), 96'(mon_es[79:0]));
                    check("sat_out_last", 96'(out_last_s), 96'(mon_es[80]));
                end
            end
            if (first_acc < 0 && in_valid && in_ready) first_acc = cyc;
            if (first_ov < 0 && out_valid) first_ov = cyc;
            if (stall_mon && out_valid && !out_ready) begin
                stall_cnt++;
                check("in_ready_stall", 96'(in_ready), 96'(0));
            end
        end
    end

    // ---------------- driver tasks (start at posedge+1) ----------------
    task automatic load_w(input logic [31:0] wd);
        int n;
        n = 0;
        w_valid = 1'b1;
        w_data  = wd;
        @(negedge clk);
        while (!w_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!w_ready) check("w_ready_timeout", 96'(0), 96'(1));
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_in(input logic signed [7:0] a, input logic [79:0] p,
                           input logic [80:0] e0, input logic [80:0] e1);
        int n;
        n = 0;
        in_valid = 1'b1;
        iact     = a;
        psum_in  = p;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 96'(0), 96'(1));
        end else begin
            exp_q.push_back(e0);
            exp_sat_q.push_back(e1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic signed [7:0] a, input logic [79:0] p);
        logic [31:0] w;
        logic        l;
        w = w_tab[m_idx];
        l = (m_idx == m_len);
        send_in(a, p, model(w, a, p, l, 1'b0), model(w, a, p, l, 1'b1));
        m_idx = (m_idx == m_len) ? 0 : m_idx + 1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_sat_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 96'(exp_q.size() + exp_sat_q.size()), 96'(0));
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        int n;
        rst = 1'b0; cfg_len_m1 = 8'd2; reload = 1'b0;
        w_valid = 1'b0; w_data = '0; in_valid = 1'b0; iact = '0; psum_in = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_psum_out",  96'(psum_out),  96'(0));
        check("rst_out_last",  96'(out_last),  96'(0));
        check("rst_in_ready",  96'(in_ready),  96'(0));
        check("rst_w_ready",   96'(w_ready),   96'(1));
        check("rst_busy",      96'(busy),      96'(0));
        check("rst_state",     96'(state_dbg), 96'(S_LOAD));
        check("rst_sat_w_ready", 96'(w_ready_s), 96'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic load of 3 words and 3 inputs
        load_w(pw(1, 2, 3, 4));
        check("load1_state", 96'(state_dbg), 96'(S_LOAD));
        load_w(pw(-1, -1, -1, -1));
        load_w(pw(0, 5, 0, 5));
        check("load_done_state", 96'(state_dbg), 96'(S_COMPUTE));
        check("load_done_busy",  96'(busy),      96'(1));
        check("load_done_wrdy",  96'(w_ready),   96'(0));
        w_tab[0] = pw(1, 2, 3, 4); w_tab[1] = pw(-1, -1, -1, -1); w_tab[2] = pw(0, 5, 0, 5);
        m_len = 2; m_idx = 0;
        first_acc = -1; first_ov = -1;
        send_in(8'sd3, pp(0, 0, 0, 0), {1'b0, pp(3, 6, 9, 12)},    {1'b0, pp(3, 6, 9, 12)});
        send_in(8'sd3, pp(0, 0, 0, 0), {1'b0, pp(-3, -3, -3, -3)}, {1'b0, pp(-3, -3, -3, -3)});
        send_in(8'sd3, pp(0, 0, 0, 0), {1'b1, pp(0, 15, 0, 15)},   {1'b1, pp(0, 15, 0, 15)});
        wait_drain();
        check("latency", 96'(first_ov - first_acc), 96'(2));

        // Cyclic replay over 7 back-to-back inputs
        c0 = cyc;
        for (int k = 0; k < 7; k++) begin
            send_m(8'(k + 1), pp(k * 100, -k * 50, k, 1000));
        end
        check("throughput", 96'(cyc - c0), 96'(7));
        wait_drain();

        // Back-pressure mid-stream
        stall_mon = 1'b1;
        stall_cnt = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send_m(8'(2 * k - 7), pp(k, -k, 3 * k, 7));
                end
            end
            begin
                repeat (3) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        stall_mon = 1'b0;
        check("stall_cycles", 96'(stall_cnt), 96'(5));

        // Reload in the same cycle as an accepted input
        cfg_len_m1 = 8'd0;
        in_valid = 1'b1; iact = 8'sd5; psum_in = pp(1, 2, 3, 4); reload = 1'b1;
        @(negedge clk);
        check("in_ready_reload", 96'(in_ready), 96'(1));
        if (in_ready) begin
            exp_q.push_back(model(w_tab[m_idx], 8'sd5, pp(1, 2, 3, 4), m_idx == m_len, 1'b0));
            exp_sat_q.push_back(model(w_tab[m_idx], 8'sd5, pp(1, 2, 3, 4), m_idx == m_len, 1'b1));
        end
        @(posedge clk); #1;
        reload = 1'b0; in_valid = 1'b0;
        check("drain_state",    96'(state_dbg), 96'(S_DRAIN));
        check("drain_in_ready", 96'(in_ready),  96'(0));
        check("drain_busy",     96'(busy),      96'(1));
        n = 0;
        @(negedge clk);
        while (!w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reload_w_ready", 96'(w_ready), 96'(1));
        check("reload_busy",    96'(busy),    96'(0));
        check("reload_drained", 96'(exp_q.size()), 96'(0));
        @(posedge clk); #1;

        // Saturation vs wrap with a single-word kernel
        load_w(pw(127, 127, 127, 127));
        check("len0_state", 96'(state_dbg), 96'(S_COMPUTE));
        w_tab[0] = pw(127, 127, 127, 127); m_len = 0; m_idx = 0;
        send_in(8'sd127, pp(524287, 524287, 524287, 524287),
                {1'b1, pp(-508160, -508160, -508160, -508160)},
                {1'b1, pp(524287, 524287, 524287, 524287)});
        send_in(-8'sd127, pp(-524288, -524288, -524288, -524288),
                {1'b1, pp(508159, 508159, 508159, 508159)},
                {1'b1, pp(-524288, -524288, -524288, -524288)});
        send_in(8'sd2, pp(10, 20, 30, 40),
                {1'b1, pp(264, 274, 284, 294)},
                {1'b1, pp(264, 274, 284, 294)});
        wait_drain();

        // Async reset while an output is held
        out_ready = 1'b0;
        send_in(8'sd1, pp(0, 0, 0, 0), {1'b1, pp(127, 127, 127, 127)}, {1'b1, pp(127, 127, 127, 127)});
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ov_before_rst", 96'(out_valid), 96'(1));
        #2;
        cfg_len_m1 = 8'd1;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 96'(out_valid), 96'(0));
        check("arst_psum_out",  96'(psum_out),  96'(0));
        check("arst_in_ready",  96'(in_ready),  96'(0));
        check("arst_w_ready",   96'(w_ready),   96'(1));
        check("arst_state",     96'(state_dbg), 96'(S_LOAD));
        exp_q.delete();
        exp_sat_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_w_ready", 96'(w_ready), 96'(1));
        check("post_rst_busy",    96'(busy),    96'(0));

        // Length sampled at deassertion (two words)
        load_w(pw(2, 2, 2, 2));
        check("post_rst_load1", 96'(state_dbg), 96'(S_LOAD));
        load_w(pw(-3, 1, 0, 7));
        check("post_rst_load2", 96'(state_dbg), 96'(S_COMPUTE));
        w_tab[0] = pw(2, 2, 2, 2); w_tab[1] = pw(-3, 1, 0, 7); m_len = 1; m_idx = 0;
        send_in(8'sd4, pp(0, 0, 0, 0), {1'b0, pp(8, 8, 8, 8)},     {1'b0, pp(8, 8, 8, 8)});
        send_in(8'sd4, pp(1, 1, 1, 1), {1'b1, pp(-11, 5, 1, 29)},  {1'b1, pp(-11, 5, 1, 29)});
        wait_drain();

        check("final_q",     96'(exp_q.size()),     96'(0));
        check("final_sat_q", 96'(exp_sat_q.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
